un_bitand_seq: RTL and testbench
================================

# un_bitand_seq

Multi-beat sequencer for the unary reduction-AND datapath. Streams an arbitrarily long operand in CHUNK_W-bit beats over a valid/ready handshake, accumulates the `&` reduction across beats through one shared masked-reduction unit, and returns the 1-bit result extended to OUT_W bits with signed or unsigned semantics. It sits between operand producers in the SV cosim harness and the result consumer, and exercises the same reduction, extension and truncation rules as the combinational operator.

## Interface
- `CHUNK_W`, 32: data bits per input beat.
- `MAX_BEATS`, 8: maximum beats per operand; operand is force-terminated at this count.
- `OUT_W`, 6: result width after extension; must be at least 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: beat available.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_data` in CHUNK_W: operand bits; only the low `in_nbits` bits are significant.
- `in_nbits` in $clog2(CHUNK_W+1): significant bit count of this beat; values above CHUNK_W clamp to CHUNK_W.
- `in_last` in 1: final beat of the operand.
- `in_signed` in 1: extension mode, sampled on the first beat only.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer takes the result.
- `out_data` out OUT_W: extended reduction result.
- `out_beats` out $clog2(MAX_BEATS+1): beats consumed for this operand.
- `out_trunc` out 1: operand hit MAX_BEATS without `in_last`.

## Operation
- The state machine has three states: IDLE, ACCUM and DONE. A beat is accepted when `in_valid && in_ready`.
- **IDLE:** `in_ready`=1.
  - On accept, set `acc` = masked reduction of the beat, `beats`=1, and latch `in_signed`.
  - If `in_last` is set, or MAX_BEATS==1, go to DONE. Otherwise go to ACCUM.
- **ACCUM:** `in_ready`=1.
  - On accept, `acc &= reduction`, `beats++`.
  - If `in_last` is set, go to DONE.
  - Otherwise, if `beats` reaches MAX_BEATS, set `out_trunc`=1 and go to DONE.
- **DONE:** `in_ready`=0, `out_valid`=1, and outputs are stable. When `out_ready` is asserted, go to IDLE and clear `out_trunc`.
- **Masked reduction:** `&(in_data | ~mask)`, where `mask` has the low `in_nbits` bits set.
  - A beat with `in_nbits`=0 contributes 1, the identity.
  - An operand of only zero-bit beats therefore yields `acc`=1.
- **Extension:**
  - Unsigned: `out_data` = zero-extended `acc`, i.e. bit 0 = `acc` and the rest 0.
  - Signed: `out_data` = OUT_W copies of `acc`.
  - For OUT_W=1 both modes give `acc`.
- `in_signed`, `in_nbits` and `in_data` on non-accepted cycles are ignored.
- Beats offered while in DONE are not accepted and must be held by the producer.

## Timing
- **Reset:**
  - Applies on the clock edge where `reset`=1 and overrides all other inputs that cycle.
  - Resulting values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_beats`=0, `out_trunc`=0, `acc`=1.
  - Reset mid-ACCUM or mid-DONE discards the partial or held result; no output is produced for it.
- **Latency:** `out_valid` rises the cycle after the last beat is accepted.
- **Throughput:** one operand per (beats + 1) cycles minimum. `in_ready` returns to 1 the cycle after the out handshake.
- **Back-to-back beats:** accepted every cycle in IDLE/ACCUM, with no bubbles.
- **Forced termination:** a beat with `in_last` accepted exactly at beat MAX_BEATS is a normal completion, `out_trunc`=0. Truncation is flagged only when beat MAX_BEATS arrives without `in_last`.
- **Consumer stall:** `out_ready` held low keeps DONE indefinitely with outputs unchanged.
- **Registered outputs:** `out_data`, `out_beats` and `out_trunc` are registered. `in_ready` and `out_valid` decode from state only and are never combinational on `in_valid` or `out_ready`.

## Structure
- Package `un_bitand_pkg`:
  - state enum (`IDLE`, `ACCUM`, `DONE`);
  - function `bitand_ext(acc, signed_mode)` returning an OUT_W vector (parameterized via width argument or localparam);
  - function building the low-bit mask from `in_nbits` with clamping.
- Sub-module `un_bitand_chunk`:
  - combinational masked reduction of one beat;
  - parameter CHUNK_W, inputs data and nbits, output 1-bit reduction.
  - This is the shared reduction unit, instantiated once.
- Top `un_bitand_seq` holds the FSM, accumulator, beat counter and output registers.

## Test plan
- Single beat, `in_nbits`=9, `in_data`=0x1FF, unsigned, OUT_W=6 → `out_data`=6'b000001, `out_beats`=1, `out_trunc`=0, one cycle after accept.
- Single beat, `in_nbits`=3, `in_data`=0xFFFFFFF7 (bit 3 ignored), signed → `out_data`=6'b111111. Same with `in_data`=0x5 → 6'b000000.
- Three beats of all ones with beat 2 bit 17 = 0, `in_nbits`=32 each, `in_last` on beat 3 → `acc`=0, `out_data`=0, `out_beats`=3.
- Eight beats of all ones, no `in_last` (MAX_BEATS=8) → `out_trunc`=1, `out_beats`=8, `out_data`=1 unsigned. A follow-up operand after handshake shows `out_trunc`=0.
- Result held with `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0 throughout, outputs stable. Next operand accepted the cycle after `out_ready`.
- `reset` asserted during beat 2 of a 4-beat operand → next cycle IDLE, `out_valid`=0, `out_data`=0; the next single beat `in_nbits`=0 operand yields `out_data`=1.

Source files
------------

// File: rtl/un_bitand_pkg.sv
// Shared types and helpers for the multi-beat reduction-AND sequencer.
// Holds the beat mask builder and the signed/unsigned result extension.
package un_bitand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Widest beat and widest extended result the helpers can produce.
    localparam int unsigned MASK_MAX_W = 1024;
    localparam int unsigned EXT_MAX_W  = 64;

    function automatic logic [MASK_MAX_W-1:0] bitand_mask(
        input int unsigned nbits,
        input int unsigned chunk_w
    );
        int unsigned n;
        n = (nbits > chunk_w) ? chunk_w : nbits;
        if (n >= MASK_MAX_W) begin
            return {MASK_MAX_W{1'b1}};
        end
        return ~({MASK_MAX_W{1'b1}} << n);
    endfunction

    function automatic logic [EXT_MAX_W-1:0] bitand_ext(
        input logic        acc,
        input logic        signed_mode,
        input int unsigned out_w
    );
        logic [EXT_MAX_W-1:0] full;
        logic [EXT_MAX_W-1:0] keep;
        full = signed_mode ? {EXT_MAX_W{acc}} : {{(EXT_MAX_W-1){1'b0}}, acc};
        keep = (out_w >= EXT_MAX_W) ? {EXT_MAX_W{1'b1}} : ~({EXT_MAX_W{1'b1}} << out_w);
        return full & keep;
    endfunction

endpackage

// File: rtl/un_bitand_chunk.sv
// Masked reduction-AND of one beat: bits at or above nbits are forced to 1,
// so a zero-bit beat yields the identity 1.
module un_bitand_chunk
    import un_bitand_pkg::*;
#(
    parameter  int CHUNK_W = 32,
    localparam int NB_W    = $clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] data_i,
    input  logic [NB_W-1:0]    nbits_i,
    output logic               red_o
);

    logic [MASK_MAX_W-1:0] mask_full;
    logic [MASK_MAX_W-1:0] data_full;

    // Pad above the beat with ones; the clamped mask is zero there, so the
    // padding never affects the result.
    always_comb begin
        mask_full = bitand_mask(32'(nbits_i), CHUNK_W);
        data_full = {{(MASK_MAX_W - CHUNK_W){1'b1}}, data_i};
        red_o     = &(data_full | ~mask_full);
    end

endmodule

// File: rtl/un_bitand_seq.sv
// Multi-beat reduction-AND sequencer: accumulates the masked & of each beat
// and returns the 1-bit result extended to OUT_W bits.
//
// state | meaning
// IDLE  | waiting for the first beat of an operand
// ACCUM | first beat taken, folding further beats into acc
// DONE  | result held on the outputs until the consumer takes it
module un_bitand_seq
    import un_bitand_pkg::*;
#(
    parameter  int CHUNK_W   = 32,
    parameter  int MAX_BEATS = 8,
    parameter  int OUT_W     = 6,
    localparam int NB_W      = $clog2(CHUNK_W + 1),
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [CHUNK_W-1:0] in_data_i,
    input  logic [NB_W-1:0]    in_nbits_i,
    input  logic               in_last_i,
    input  logic               in_signed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   out_data_o,
    output logic [BEAT_W-1:0]  out_beats_o,
    output logic               out_trunc_o
);

    state_e              state_q;
    logic                acc_q;
    logic                signed_q;
    logic [BEAT_W-1:0]   beats_q;
    logic [OUT_W-1:0]    out_data_q;
    logic [BEAT_W-1:0]   out_beats_q;
    logic                out_trunc_q;

    logic                beat_red;
    logic                accept;
    logic                acc_d;
    logic                signed_d;
    logic [BEAT_W-1:0]   beats_d;
    logic                hit_max;
    logic [EXT_MAX_W-1:0] ext_full;
    logic [EXT_MAX_W-OUT_W-1:0] ext_unused_bits;

    un_bitand_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk (
        .data_i  (in_data_i),
        .nbits_i (in_nbits_i),
        .red_o   (beat_red)
    );

    assign in_ready_o  = (state_q != DONE);
    assign out_valid_o = (state_q == DONE);
    assign accept      = in_valid_i && in_ready_o;

    // In IDLE the beat starts a fresh operand, so hit_max there covers MAX_BEATS==1.
    always_comb begin
        acc_d    = (state_q == IDLE) ? beat_red : (acc_q & beat_red);
        signed_d = (state_q == IDLE) ? in_signed_i : signed_q;
        beats_d  = (state_q == IDLE) ? BEAT_W'(1) : (beats_q + BEAT_W'(1));
        hit_max  = (beats_d == BEAT_W'(MAX_BEATS));
        ext_full = bitand_ext(acc_d, signed_d, OUT_W);
    end

    assign ext_unused_bits = ext_full[EXT_MAX_W-1:OUT_W];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            acc_q       <= 1'b1;
            signed_q    <= 1'b0;
            beats_q     <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q    <= acc_d;
                        signed_q <= signed_d;
                        beats_q  <= beats_d;
                        if (in_last_i || hit_max) begin
                            state_q     <= DONE;
                            out_data_q  <= ext_full[OUT_W-1:0];
                            out_beats_q <= beats_d;
                            out_trunc_q <= !in_last_i;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        acc_q       <= 1'b1;
                        beats_q     <= '0;
                        out_trunc_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= 1'b1;
                    beats_q <= '0;
                end
            endcase
        end
    end

    assign out_data_o  = out_data_q;
    assign out_beats_o = out_beats_q;
    assign out_trunc_o = out_trunc_q;

endmodule

// File: tb/tb_un_bitand_seq.sv
// Randomized and directed bench for un_bitand_seq against a per-operand
// reference model computed from bit-level reduction rules.
module tb_un_bitand_seq;

    localparam int CW = 32;
    localparam int MB = 8;
    localparam int OW = 6;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic [5:0]  in_nbits_i;
    logic        in_last_i;
    logic        in_signed_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  out_data_o;
    logic [3:0]  out_beats_o;
    logic        out_trunc_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] bd [16];
    int          bn [16];
    logic        bl [16];
    logic        bs [16];
    int          nb;

    always #5 clk_i = ~clk_i;

    un_bitand_seq #(
        .CHUNK_W   (CW),
        .MAX_BEATS (MB),
        .OUT_W     (OW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_nbits_i  (in_nbits_i),
        .in_last_i   (in_last_i),
        .in_signed_i (in_signed_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_beats_o (out_beats_o),
        .out_trunc_o (out_trunc_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic beat_ref(input logic [31:0] d, input int nbits);
        int n;
        n = (nbits > CW) ? CW : nbits;
        for (int i = 0; i < n; i++) begin
            if (d[i] == 1'b0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic set_beat(input int i, input logic [31:0] d, input int n,
                            input logic last, input logic s);
        bd[i] = d;
        bn[i] = n;
        bl[i] = last;
        bs[i] = s;
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        in_data_i   = $urandom;
        in_nbits_i  = 6'($urandom);
        in_last_i   = 1'($urandom);
        in_signed_i = 1'($urandom);
    endtask

    // Drives the nb staged beats (stopping where the operand terminates),
    // then holds the result for 'stall' cycles before the out handshake.
    task automatic run_op(input int stall, input bit gaps);
        int          used;
        logic        acc;
        logic        trunc;
        logic [5:0]  exp_out;
        used  = 0;
        acc   = 1'b1;
        trunc = 1'b0;
        for (int b = 0; b < nb; b++) begin
            used = b + 1;
            acc  = acc & beat_ref(bd[b], bn[b]);
            if (bl[b]) break;
            if (used == MB) begin
                trunc = 1'b1;
                break;
            end
        end
        exp_out = bs[0] ? {6{acc}} : {5'b0, acc};

        for (int b = 0; b < used; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                idle_inputs();
                tick();
                check_eq("gap_out_valid", 32'(out_valid_o), 32'(0));
            end
            in_valid_i  = 1'b1;
            in_data_i   = bd[b];
            in_nbits_i  = 6'(bn[b]);
            in_last_i   = bl[b];
            in_signed_i = bs[b];
            check_eq("in_ready_beat", 32'(in_ready_o), 32'(1));
            tick();
            if (b < used - 1) check_eq("out_valid_mid", 32'(out_valid_o), 32'(0));
        end

        idle_inputs();
        check_eq("out_valid", 32'(out_valid_o), 32'(1));
        check_eq("in_ready_done", 32'(in_ready_o), 32'(0));
        check_eq("out_data", 32'(out_data_o), 32'(exp_out));
        check_eq("out_beats", 32'(out_beats_o), 32'(used));
        check_eq("out_trunc", 32'(out_trunc_o), 32'(trunc));

        for (int s = 0; s < stall; s++) begin
            in_valid_i  = 1'b1;
            in_data_i   = $urandom;
            in_nbits_i  = 6'($urandom);
            in_last_i   = 1'($urandom);
            in_signed_i = 1'($urandom);
            out_ready_i = 1'b0;
            tick();
            check_eq("stall_in_ready", 32'(in_ready_o), 32'(0));
            check_eq("stall_out_valid", 32'(out_valid_o), 32'(1));
            check_eq("stall_out_data", 32'(out_data_o), 32'(exp_out));
            check_eq("stall_out_beats", 32'(out_beats_o), 32'(used));
            check_eq("stall_out_trunc", 32'(out_trunc_o), 32'(trunc));
        end

        idle_inputs();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check_eq("post_hs_out_valid", 32'(out_valid_o), 32'(0));
        check_eq("post_hs_in_ready", 32'(in_ready_o), 32'(1));
        check_eq("post_hs_trunc", 32'(out_trunc_o), 32'(0));
    endtask

    initial begin
        reset_i     = 1'b1;
        out_ready_i = 1'b0;
        idle_inputs();
        in_valid_i  = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        in_valid_i = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready_o), 32'(1));
        check_eq("rst_out_valid", 32'(out_valid_o), 32'(0));
        check_eq("rst_out_data", 32'(out_data_o), 32'(0));
        check_eq("rst_out_beats", 32'(out_beats_o), 32'(0));
        check_eq("rst_out_trunc", 32'(out_trunc_o), 32'(0));

        nb = 1; set_beat(0, 32'h0000_01FF, 9, 1'b1, 1'b0); run_op(0, 1'b0);
        nb = 1; set_beat(0, 32'hFFFF_FFF7, 3, 1'b1, 1'b1); run_op(0, 1'b0);
        nb = 1; set_beat(0, 32'h0000_0005, 3, 1'b1, 1'b1); run_op(0, 1'b0);

        nb = 3;
        set_beat(0, 32'hFFFF_FFFF, 32, 1'b0, 1'b0);
        set_beat(1, ~(32'h1 << 17), 32, 1'b0, 1'b1);
        set_beat(2, 32'hFFFF_FFFF, 32, 1'b1, 1'b1);
        run_op(0, 1'b0);

        nb = 8;
        for (int i = 0; i < 8; i++) set_beat(i, 32'hFFFF_FFFF, 32, 1'b0, 1'b0);
        run_op(0, 1'b0);
        nb = 1; set_beat(0, 32'h0000_000F, 4, 1'b1, 1'b0); run_op(0, 1'b0);

        nb = 8;
        for (int i = 0; i < 8; i++) set_beat(i, 32'hFFFF_FFFF, 32, (i == 7), 1'b1);
        run_op(0, 1'b0);

        nb = 2;
        set_beat(0, 32'hFFFF_FFFF, 63, 1'b0, 1'b1);
        set_beat(1, 32'h0000_0000, 0, 1'b1, 1'b0);
        run_op(5, 1'b0);
        nb = 1; set_beat(0, 32'h0000_0000, 1, 1'b1, 1'b0); run_op(0, 1'b0);

        in_valid_i  = 1'b1;
        in_data_i   = 32'hFFFF_FFFF;
        in_nbits_i  = 6'd32;
        in_last_i   = 1'b0;
        in_signed_i = 1'b1;
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        idle_inputs();
        check_eq("midrst_out_valid", 32'(out_valid_o), 32'(0));
        check_eq("midrst_in_ready", 32'(in_ready_o), 32'(1));
        check_eq("midrst_out_data", 32'(out_data_o), 32'(0));
        check_eq("midrst_out_trunc", 32'(out_trunc_o), 32'(0));
        nb = 1; set_beat(0, 32'h0000_0000, 0, 1'b1, 1'b0); run_op(0, 1'b0);

        for (int op = 0; op < 200; op++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                logic [31:0] d;
                case ($urandom_range(0, 3))
                    0:       d = $urandom;
                    1:       d = ~(32'h1 << $urandom_range(0, 31));
                    default: d = 32'hFFFF_FFFF;
                endcase
                set_beat(b, d, $urandom_range(0, 63), 1'b0, 1'($urandom));
            end
            bl[nb-1] = (nb < MB) ? 1'b1 : 1'($urandom);
            run_op($urandom_range(0, 3), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
